// File: rtl/fpu_mul_post_if.sv
// Bus bundle for the post-multiply normalize/round stage.
// The master side issues operations and supplies the product. The slave side
// (the fpu_mul_post stage) returns the packed result and the exception flags.
interface fpu_mul_post_if;
    logic        in_valid;
    logic        sign_in;
    logic [9:0]  exp_in;
    logic [1:0]  rmode;
    logic [47:0] prod;
    logic        out_valid;
    logic [31:0] out;
    logic        ovf;
    logic        unf;
    logic        inexact;

    modport master (
        output in_valid, sign_in, exp_in, rmode, prod,
        input  out_valid, out, ovf, unf, inexact
    );

    modport slave (
        input  in_valid, sign_in, exp_in, rmode, prod,
        output out_valid, out, ovf, unf, inexact
    );
endinterface

// File: rtl/fpu_mul_post.sv
// fpu_mul_post: normalize, round and pack stage behind the 2-cycle 24x24
// mantissa multiplier. Sign, exponent and rounding mode ride a 2-entry side
// pipeline so that they line up with the product. The result is registered
// one cycle later, so a result appears 3 cycles after issue.
// Optional feature: define FPU_MUL_POST_FLAGS_EN to build the ovf/unf/inexact
// flag logic. Without it the flags are tied to 0 and the packed result is
// unchanged.
module fpu_mul_post (
    input  logic         clk,
    input  logic         reset,
    fpu_mul_post_if.slave bus
);

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RZ  = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rmode_t;

    typedef struct packed {
        logic       valid;
        logic       sign;
        logic [9:0] exp;
        logic [1:0] rmode;
    } side_t;

    side_t       s1_q, s1_d, s2_q, s2_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_q, out_d;

    logic [22:0]        frac;
    logic               guard;
    logic               sticky;
    logic               incr;
    logic [23:0]        rounded;
    logic signed [9:0]  e_norm;
    logic signed [9:0]  e_fin;
    logic               is_zero;
    logic               is_unf;
    logic               is_ovf;
    logic               away;
    logic [31:0]        result;
    rmode_t             mode;

    // Side pipeline advance: stage 1 samples the issue, stage 2 lines up with prod
    always_comb begin
        s1_d       = '0;
        s1_d.valid = bus.in_valid;
        s1_d.sign  = bus.sign_in;
        s1_d.exp   = bus.exp_in;
        s1_d.rmode = bus.rmode;
        s2_d       = s1_q;
    end

    // Normalize, round and pack the product against the stage-2 side entry
    always_comb begin
        mode    = rmode_t'(s2_q.rmode);
        is_zero = (bus.prod == 48'd0);
        if (bus.prod[47]) begin
            frac   = bus.prod[46:24];
            guard  = bus.prod[23];
            sticky = |bus.prod[22:0];
            e_norm = $signed(s2_q.exp) + 10'sd1;
        end else begin
            frac   = bus.prod[45:23];
            guard  = bus.prod[22];
            sticky = |bus.prod[21:0];
            e_norm = $signed(s2_q.exp);
        end
        case (mode)
            RM_RNE:  incr = guard & (sticky | frac[0]);
            RM_RZ:   incr = 1'b0;
            RM_RUP:  incr = ~s2_q.sign & (guard | sticky);
            default: incr = s2_q.sign & (guard | sticky);
        endcase
        rounded = {1'b0, frac} + {23'd0, incr};
        e_fin   = rounded[23] ? (e_norm + 10'sd1) : e_norm;
        is_unf  = !is_zero && (e_norm <= 10'sd0);
        is_ovf  = !is_zero && !is_unf && (e_fin >= 10'sd255);
        away    = (mode == RM_RNE) ||
                  ((mode == RM_RUP) && !s2_q.sign) ||
                  ((mode == RM_RDN) && s2_q.sign);
        if (is_zero || is_unf) begin
            result = {s2_q.sign, 31'd0};
        end else if (is_ovf) begin
            result = away ? {s2_q.sign, 31'h7F80_0000} : {s2_q.sign, 31'h7F7F_FFFF};
        end else begin
            result = {s2_q.sign, e_fin[7:0], rounded[22:0]};
        end
        out_valid_d = s2_q.valid;
        out_d       = s2_q.valid ? result : out_q;
    end

    // Pipeline registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= 32'd0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;

`ifdef FPU_MUL_POST_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
    logic inexact_q, inexact_d;

    // Flags follow the result: updated on a valid stage-2 entry, held otherwise
    always_comb begin
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        inexact_d = inexact_q;
        if (s2_q.valid) begin
            ovf_d     = is_ovf;
            unf_d     = is_unf;
            inexact_d = !is_zero && (is_ovf || is_unf || guard || sticky);
        end
    end

    // Flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            inexact_q <= inexact_d;
        end
    end

    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
    assign bus.inexact = inexact_q;
`else
    assign bus.ovf     = 1'b0;
    assign bus.unf     = 1'b0;
    assign bus.inexact = 1'b0;
`endif

endmodule
